// File: rtl/mdr_mem_ctrl.sv
//==============================================================================
// Module  : mdr_mem_ctrl
// Brief   : Memory data register with a req/ack handshake to main RAM.
//           Captures bus data for stores, runs one read or write per command
//           and returns the fetched word to the bus.
// Option  : MDR_TIMEOUT_EN adds an ack-wait timeout with a sticky err flag.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mdr_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MDRin,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] mar_addr,
  output logic [DATA_W-1:0] mdr_q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mdr,   w_mdr_nxt;
  logic              r_req,   w_req_nxt;
  logic              r_we,    w_we_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;

`ifdef MDR_TIMEOUT_EN
  // The counter hits TIMEOUT on the edge that follows this value.
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_err, w_err_nxt;
`endif

  // State register and datapath registers; clr clears everything at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_mdr   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
`ifdef MDR_TIMEOUT_EN
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_mdr   <= w_mdr_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
`ifdef MDR_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  // Next-state and next-register logic for the transaction sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_mdr_nxt   = r_mdr;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
`ifdef MDR_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        // A read overwrites the MDR later, so a coincident load is dropped.
        if (MDRin && !read) begin
          w_mdr_nxt = bus_in;
        end
        if (read || write) begin
          w_state_nxt = read ? S_RD : S_WR;
          w_we_nxt    = !read;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = mar_addr;
`ifdef MDR_TIMEOUT_EN
          w_cnt_nxt   = 8'd0;
          w_err_nxt   = 1'b0;
`endif
        end
      end
      S_RD, S_WR: begin
        // An ack always beats a timeout landing on the same edge.
        if (mem_ack) begin
          if (r_state == S_RD) begin
            w_mdr_nxt = mem_rdata;
          end
          w_req_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end
`ifdef MDR_TIMEOUT_EN
        else if (r_cnt == c_cnt_last) begin
          w_cnt_nxt   = r_cnt + 8'd1;
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mdr_q     = r_mdr;
  assign mem_wdata = r_mdr;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

`ifdef MDR_TIMEOUT_EN
  assign err = r_err;
`else
  // Without the timeout option the limit has no consumer.
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT);
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire
